// File: rtl/hazard_scheduler.sv
// Issue control between decode and execute: a shift-register scoreboard of
// in-flight register writes detects RAW hazards, a small branch FSM holds
// fetch until the branch resolves and flushes when it is taken, and a
// saturating counter records cycles in which a valid instruction was held.
module hazard_scheduler #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_valid,
  input  logic [7:0]       d_addr_a,
  input  logic [7:0]       d_addr_b,
  input  logic             d_regwrite,
  input  logic [7:0]       d_write_addr,
  input  logic             d_branch,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             issue,
  output logic             halt_fetch,
  output logic             halt_decode,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BR_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [STAGES-1:0] sb_valid;
  logic [7:0]        sb_wa [STAGES];
  logic              raw_hazard;

  // A source operand collides with any write still in flight; register 0 is
  // treated like every other register.
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (sb_valid[i] && ((sb_wa[i] == d_addr_a) || (sb_wa[i] == d_addr_b))) begin
        raw_hazard = 1'b1;
      end
    end
  end

  // Scoreboard shifts every cycle; entry 0 takes the issuing write or a bubble.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sb_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sb_wa[i] <= '0;
      end
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_wa[i]    <= sb_wa[i-1];
      end
      sb_valid[0] <= issue & d_regwrite;
      sb_wa[0]    <= d_write_addr;
    end
  end

  // Branch state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs; flush and the FLUSH-cycle fetch release
  // are decoded from the registered state only, so they cannot glitch.
  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    flush       = 1'b0;
    halt_decode = 1'b0;
    halt_fetch  = 1'b0;
    case (state)
      S_IDLE: begin
        issue = d_valid & ~raw_hazard;
        if (issue && d_branch) begin
          state_next = S_BR_WAIT;
        end
      end
      S_BR_WAIT: begin
        if (br_resolve) begin
          state_next = br_taken ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        flush      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    halt_decode = (d_valid & ~issue) | (state == S_BR_WAIT);
    if (state == S_FLUSH) begin
      halt_fetch = 1'b0;
    end else begin
      halt_fetch = halt_decode | (state == S_BR_WAIT) | (issue & d_branch);
    end
  end

  // Saturating count of cycles where decode held a valid instruction that
  // did not issue.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_count <= '0;
    end else if (d_valid && !issue && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler. Each vector carries its
// hand-computed expected outputs, which are queued when the vector is driven
// and compared by an independent monitor on the falling clock edge. A second
// instance with a 4-bit counter shares the same inputs to exercise saturation.
module tb_hazard_scheduler;

  typedef struct {
    string       name;
    logic        issue;
    logic        halt_fetch;
    logic        halt_decode;
    logic        flush;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk;
  logic        n_rst;
  logic        d_valid;
  logic [7:0]  d_addr_a;
  logic [7:0]  d_addr_b;
  logic        d_regwrite;
  logic [7:0]  d_write_addr;
  logic        d_branch;
  logic        br_resolve;
  logic        br_taken;

  logic        issue_a, halt_fetch_a, halt_decode_a, flush_a;
  logic [15:0] stall_count_a;
  logic        issue_b, halt_fetch_b, halt_decode_b, flush_b;
  logic [3:0]  stall_count_b;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_scheduler #(.STAGES(3), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .d_valid(d_valid),
    .d_addr_a(d_addr_a), .d_addr_b(d_addr_b),
    .d_regwrite(d_regwrite), .d_write_addr(d_write_addr),
    .d_branch(d_branch), .br_resolve(br_resolve), .br_taken(br_taken),
    .issue(issue_a), .halt_fetch(halt_fetch_a), .halt_decode(halt_decode_a),
    .flush(flush_a), .stall_count(stall_count_a)
  );

  hazard_scheduler #(.STAGES(3), .CNT_W(4)) dut_sat (
    .clk(clk), .n_rst(n_rst), .d_valid(d_valid),
    .d_addr_a(d_addr_a), .d_addr_b(d_addr_b),
    .d_regwrite(d_regwrite), .d_write_addr(d_write_addr),
    .d_branch(d_branch), .br_resolve(br_resolve), .br_taken(br_taken),
    .issue(issue_b), .halt_fetch(halt_fetch_b), .halt_decode(halt_decode_b),
    .flush(flush_b), .stall_count(stall_count_b)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(
    input string name, input logic rst, input logic dv,
    input logic [7:0] a, input logic [7:0] b, input logic rw, input logic [7:0] wa,
    input logic br, input logic res, input logic tk,
    input logic e_issue, input logic e_hf, input logic e_hd, input logic e_fl,
    input int e_c16, input int e_c4);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst        = rst;
    d_valid      = dv;
    d_addr_a     = a;
    d_addr_b     = b;
    d_regwrite   = rw;
    d_write_addr = wa;
    d_branch     = br;
    br_resolve   = res;
    br_taken     = tk;
    e.name        = name;
    e.issue       = e_issue;
    e.halt_fetch  = e_hf;
    e.halt_decode = e_hd;
    e.flush       = e_fl;
    e.cnt16       = 16'(e_c16);
    e.cnt4        = 4'(e_c4);
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are presented every cycle; compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.name, ".issue"},       32'(issue_a),       32'(e.issue));
      checkOutput({e.name, ".halt_fetch"},  32'(halt_fetch_a),  32'(e.halt_fetch));
      checkOutput({e.name, ".halt_decode"}, 32'(halt_decode_a), 32'(e.halt_decode));
      checkOutput({e.name, ".flush"},       32'(flush_a),       32'(e.flush));
      checkOutput({e.name, ".stall_count"}, 32'(stall_count_a), 32'(e.cnt16));
      checkOutput({e.name, ".stall_count4"}, 32'(stall_count_b), 32'(e.cnt4));
      checkOutput({e.name, ".issue4"},      32'(issue_b),       32'(e.issue));
    end
  end

  initial begin
    int drain;
    n_rst = 1'b0; d_valid = 1'b0; d_addr_a = '0; d_addr_b = '0;
    d_regwrite = 1'b0; d_write_addr = '0; d_branch = 1'b0;
    br_resolve = 1'b0; br_taken = 1'b0;

    // Reset and first idle cycle.
    applyStimulus("rst",   0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    applyStimulus("idle",  1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);

    // Independent stream.
    applyStimulus("ind1",  1, 1, 10, 11, 1, 1, 0, 0, 0,  1, 0, 0, 0,  0, 0);
    applyStimulus("ind2",  1, 1, 10, 11, 1, 2, 0, 0, 0,  1, 0, 0, 0,  0, 0);
    applyStimulus("ind3",  1, 1, 10, 11, 1, 3, 0, 0, 0,  1, 0, 0, 0,  0, 0);

    // RAW on r5: three blocked cycles, then issue.
    applyStimulus("prod5", 1, 1, 10, 11, 1, 5, 0, 0, 0,  1, 0, 0, 0,  0, 0);
    applyStimulus("raw1",  1, 1,  5, 11, 1, 6, 0, 0, 0,  0, 1, 1, 0,  0, 0);
    applyStimulus("raw2",  1, 1,  5, 11, 1, 6, 0, 0, 0,  0, 1, 1, 0,  1, 1);
    applyStimulus("raw3",  1, 1,  5, 11, 1, 6, 0, 0, 0,  0, 1, 1, 0,  2, 2);
    applyStimulus("rawgo", 1, 1,  5, 11, 1, 6, 0, 0, 0,  1, 0, 0, 0,  3, 3);

    // Not-taken branch; a later stray resolve in IDLE is ignored.
    applyStimulus("nt_br",   1, 1, 20, 21, 0, 0, 1, 0, 0,  1, 1, 0, 0,  3, 3);
    applyStimulus("nt_wait", 1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 1, 1, 0,  3, 3);
    applyStimulus("nt_res",  1, 0,  0,  0, 0, 0, 0, 1, 0,  0, 1, 1, 0,  3, 3);
    applyStimulus("nt_idle", 1, 1, 20, 21, 0, 0, 0, 1, 1,  1, 0, 0, 0,  3, 3);
    applyStimulus("nt_qt",   1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3, 3);

    // Taken branch: one flush cycle with fetch released.
    applyStimulus("tk_br",   1, 1, 20, 21, 0, 0, 1, 0, 0,  1, 1, 0, 0,  3, 3);
    applyStimulus("tk_wait", 1, 1, 30, 31, 0, 0, 0, 0, 0,  0, 1, 1, 0,  3, 3);
    applyStimulus("tk_res",  1, 1, 30, 31, 0, 0, 0, 1, 1,  0, 1, 1, 0,  4, 4);
    applyStimulus("tk_fl",   1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  5, 5);
    applyStimulus("tk_idle", 1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  5, 5);

    // Branch blocked by a hazard neither issues nor leaves IDLE.
    applyStimulus("prod7",   1, 1, 10, 11, 1, 7, 0, 0, 0,  1, 0, 0, 0,  5, 5);
    applyStimulus("brraw",   1, 1,  7, 11, 0, 0, 1, 0, 0,  0, 1, 1, 0,  5, 5);
    applyStimulus("brraw_q", 1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  6, 6);

    // Long branch wait with decode valid: the 4-bit counter stops at 15.
    applyStimulus("sat_br",  1, 1, 40, 41, 0, 0, 1, 0, 0,  1, 1, 0, 0,  6, 6);
    for (int k = 0; k < 20; k++) begin
      applyStimulus($sformatf("sat%0d", k), 1, 1, 40, 41, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 6 + k, (6 + k > 15) ? 15 : 6 + k);
    end
    applyStimulus("sat_res", 1, 1, 40, 41, 0, 0, 0, 1, 0,  0, 1, 1, 0, 26, 15);
    applyStimulus("sat_go",  1, 1, 40, 41, 0, 0, 0, 0, 0,  1, 0, 0, 0, 27, 15);

    // Asynchronous reset while waiting on a branch that writes r9.
    applyStimulus("rb_br",   1, 1, 40, 41, 1, 9, 1, 0, 0,  1, 1, 0, 0, 27, 15);
    applyStimulus("rb_wait", 1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 27, 15);
    applyStimulus("rb_rst",  0, 0,  0,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0,  0, 0);
    applyStimulus("rb_aft",  1, 1,  9,  9, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0);
    applyStimulus("rb_qt",   1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);

    // Let the monitor drain the queue within a bounded number of cycles.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
